// File: rtl/wt_store_wbuf.sv
// wt_store_wbuf: write-through store buffer between the LSU store path and
// the L1.5 memory request port.
// Committed stores are merged at 64-bit word granularity into the youngest
// entry. Otherwise they are appended to a circular FIFO. The FIFO drains in
// order, and the number of un-acknowledged writes is bounded by MAX_OUT.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   st_valid_i/st_ready_o        store handshake
//   st_addr_i/st_data_i/st_be_i  store byte address, lane-aligned data,
//                                byte enables
//   mem_req_*                    write request to memory (head entry)
//   mem_ack_i                    one write completion per cycle
//   ld_addr_i/ld_hit_o           load hazard check against buffered words
//   empty_o                      no entries and no outstanding writes
module wt_store_wbuf #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic [DATA_W-1:0]   mem_req_data_o,
  output logic [DATA_W/8-1:0] mem_req_be_o,
  input  logic                mem_ack_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic                empty_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam int BW   = DATA_W / 8;
  localparam int WA_W = ADDR_W - 3;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  logic [WA_W-1:0]   wa_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BW-1:0]     be_q   [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic [PW-1:0] head_q, tail_q, tail_m1;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;

  logic [WA_W-1:0] st_wa, ld_wa;
  logic            pop, push, merge, merge_cond, full, youngest_popped, ack_eff;

  // Byte-offset bits do not take part in word matching.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr_i[2:0], ld_addr_i[2:0]};

  assign st_wa   = st_addr_i[ADDR_W-1:3];
  assign ld_wa   = ld_addr_i[ADDR_W-1:3];
  assign tail_m1 = tail_q - PW'(1);
  assign full    = (count_q == DEPTH_C);

  assign mem_req_valid_o = (count_q != '0) && (out_q < MAX_OUT_C);
  assign mem_req_addr_o  = {wa_q[head_q], 3'b000};
  assign mem_req_data_o  = data_q[head_q];
  assign mem_req_be_o    = be_q[head_q];
  assign pop             = mem_req_valid_o && mem_req_ready_i;

  // The youngest entry is the head only when a single entry is buffered.
  // Merging into it while it is handed off would lose the new bytes.
  assign youngest_popped = pop && (count_q == CW'(1));
  assign merge_cond      = (count_q != '0) && (wa_q[tail_m1] == st_wa) && !youngest_popped;

  // A pop in the same cycle does not free space for a new entry.
  assign st_ready_o = merge_cond || !full;
  assign merge      = st_valid_i && merge_cond;
  assign push       = st_valid_i && !merge_cond && !full;

  // Completions with nothing outstanding are dropped.
  assign ack_eff = mem_ack_i && (out_q != '0);

  assign empty_o = (count_q == '0) && (out_q == '0);

  always_comb begin
    ld_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (wa_q[i] == ld_wa)) ld_hit_o = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    out_d = out_q;
    if (pop && !ack_eff)      out_d = out_q + OW'(1);
    else if (!pop && ack_eff) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wa_q[i]   <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (push) begin
        wa_q[tail_q]   <= st_wa;
        data_q[tail_q] <= st_data_i;
        be_q[tail_q]   <= st_be_i;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + PW'(1);
      end
      if (merge) begin
        for (int b = 0; b < BW; b++) begin
          if (st_be_i[b]) data_q[tail_m1][8*b +: 8] <= st_data_i[8*b +: 8];
        end
        be_q[tail_m1] <= be_q[tail_m1] | st_be_i;
      end
    end
  end

  // A completion must always correspond to an issued write.
  ack_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                     !(mem_ack_i && (out_q == '0)));

endmodule

// File: tb/tb_wt_store_wbuf.sv
module tb_wt_store_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [63:0] st_addr, st_data;
  logic [7:0]  st_be;
  logic        req_valid, req_ready;
  logic [63:0] req_addr, req_data;
  logic [7:0]  req_be;
  logic        ack;
  logic [63:0] ld_addr;
  logic        ld_hit, empty;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wt_store_wbuf dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be),
    .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready),
    .mem_req_addr_o(req_addr), .mem_req_data_o(req_data), .mem_req_be_o(req_be),
    .mem_ack_i(ack), .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .empty_o(empty)
  );

  typedef struct {
    logic        sv;  logic [63:0] a;  logic [63:0] d;  logic [7:0] be;
    logic        rdy; logic        ak; logic [63:0] ld;
    logic        er;  logic        ev; logic [63:0] ea; logic [63:0] ed;
    logic [7:0]  ebe; logic        eh; logic        ee;
  } vec_t;

  vec_t tq[$];

  function automatic void add(input logic sv, input logic [63:0] a, input logic [63:0] d,
                              input logic [7:0] be, input logic rdy, input logic ak,
                              input logic [63:0] ld, input logic er, input logic ev,
                              input logic [63:0] ea, input logic [63:0] ed,
                              input logic [7:0] ebe, input logic eh, input logic ee);
    vec_t v;
    v.sv = sv; v.a = a; v.d = d; v.be = be; v.rdy = rdy; v.ak = ak; v.ld = ld;
    v.er = er; v.ev = ev; v.ea = ea; v.ed = ed; v.ebe = ebe; v.eh = eh; v.ee = ee;
    tq.push_back(v);
  endfunction

  // Payload is only compared when a request is expected to be valid.
  task automatic check(input string name, input vec_t v);
    logic bad;
    bad = (st_ready !== v.er) || (req_valid !== v.ev) || (ld_hit !== v.eh) ||
          (empty !== v.ee) ||
          (v.ev && ((req_addr !== v.ea) || (req_data !== v.ed) || (req_be !== v.ebe)));
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b val=%b addr=%h data=%h be=%h hit=%b empty=%b, want rdy=%b val=%b addr=%h data=%h be=%h hit=%b empty=%b",
               name, st_ready, req_valid, req_addr, req_data, req_be, ld_hit, empty,
               v.er, v.ev, v.ea, v.ed, v.ebe, v.eh, v.ee);
    end
  endtask

  task automatic run_table(input string name);
    foreach (tq[i]) begin
      @(negedge clk);
      st_valid  = tq[i].sv;  st_addr = tq[i].a; st_data = tq[i].d; st_be = tq[i].be;
      req_ready = tq[i].rdy; ack     = tq[i].ak; ld_addr = tq[i].ld;
      #1;
      check($sformatf("%s[%0d]", name, i), tq[i]);
    end
    tq.delete();
  endtask

  initial begin
    vec_t hv;
    rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_be = 0;
    req_ready = 0; ack = 0; ld_addr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single store, minimum latency, outstanding tracking through empty_o.
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table("single");

    // Two half-word stores merge into one entry while the head is stalled.
    add(1, 64'h8000_0020, 64'h0000_0000_AABB_CCDD, 8'h0F, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 64'h8000_0024, 64'h1122_3344_0000_0000, 8'hF0, 0, 0, 0, 1, 1, 64'h8000_0020, 64'h0000_0000_AABB_CCDD, 8'h0F, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0020, 64'h1122_3344_AABB_CCDD, 8'hFF, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table("merge");

    // Fill to DEPTH, reject a new word, accept a merge into the youngest, then drain.
    for (int i = 0; i < 8; i++)
      add(1, 64'h8000_0100 + 64'(8*i), 64'(i), 8'hFF, 0, 0, 0, 1, i != 0, 64'h8000_0100, 0, 8'hFF, 0, i == 0);
    add(1, 64'h8000_0200, 64'h55, 8'hFF, 0, 0, 64'h8000_013F, 0, 1, 64'h8000_0100, 0, 8'hFF, 1, 0);
    add(1, 64'h8000_013A, 64'hAB00, 8'h02, 0, 0, 64'h8000_0200, 1, 1, 64'h8000_0100, 0, 8'hFF, 0, 0);
    for (int j = 0; j < 8; j++)
      add(j == 0, 64'h8000_0208, 64'h66, 8'hFF, 1, j != 0, 0, j != 0, 1, 64'h8000_0100 + 64'(8*j),
          (j == 7) ? 64'hAB07 : 64'(j), 8'hFF, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    run_table("full");

    // Outstanding limit: seven requests issue, then one per ack, in order.
    for (int k = 0; k < 10; k++)
      add(1, 64'h8000_1000 + 64'(8*k), 64'h100 + 64'(k), 8'hFF, 1, 0, 0, 1, (k >= 1) && (k <= 7),
          64'h8000_1000 + 64'(8*(k-1)), 64'h100 + 64'(k-1), 8'hFF, 0, k == 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int m = 7; m < 10; m++) begin
      add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_1000 + 64'(8*m), 64'h100 + 64'(m), 8'hFF, 0, 0);
    end
    for (int n = 0; n < 7; n++)
      add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table("maxout");

    // Load hazard: hit while buffered, miss on a neighbour word, miss once issued.
    add(1, 64'h8000_0040, 64'h5A, 8'h01, 0, 0, 64'h8000_0047, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 64'h8000_0047, 1, 1, 64'h8000_0040, 64'h5A, 8'h01, 1, 0);
    add(0, 0, 0, 0, 0, 0, 64'h8000_0048, 1, 1, 64'h8000_0040, 64'h5A, 8'h01, 0, 0);
    add(0, 0, 0, 0, 1, 0, 64'h8000_0047, 1, 1, 64'h8000_0040, 64'h5A, 8'h01, 1, 0);
    add(0, 0, 0, 0, 1, 1, 64'h8000_0047, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table("ldhit");

    // Same word as a single head that is being popped: must allocate, not merge.
    add(1, 64'h8000_0300, 64'h01, 8'h01, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 64'h8000_0300, 64'h0200, 8'h02, 1, 0, 0, 1, 1, 64'h8000_0300, 64'h01, 8'h01, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0300, 64'h0200, 8'h02, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table("popmerge");

    // Build 3 entries with 2 outstanding, then reset asynchronously mid-drain.
    for (int i = 0; i < 5; i++)
      add(1, 64'h8000_2000 + 64'(8*i), 64'h200 + 64'(i), 8'hFF, 0, 0, 0, 1, i != 0, 64'h8000_2000, 64'h200, 8'hFF, 0, i == 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_2000, 64'h200, 8'hFF, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_2008, 64'h201, 8'hFF, 0, 0);
    run_table("prerst");

    @(negedge clk);
    st_valid = 0; ack = 0; req_ready = 1; ld_addr = 64'h8000_2010;
    #1;
    hv = '{sv:0, a:0, d:0, be:0, rdy:1, ak:0, ld:64'h8000_2010, er:1, ev:1,
           ea:64'h8000_2010, ed:64'h202, ebe:8'hFF, eh:1, ee:0};
    check("rst_before", hv);
    #1 rst = 1'b1;
    #1;
    hv.ev = 0; hv.eh = 0; hv.ee = 1;
    check("rst_async", hv);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 1, 0, 64'h8000_2010, 1, 0, 0, 0, 0, 0, 1);
    run_table("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
